// File: rtl/ex_muldiv_unit_pkg.sv
// Shared opcodes and FSM state encoding for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int MD_OP_LEN = 3;

    localparam logic [MD_OP_LEN-1:0] MD_OP_MUL   = 3'd0;
    localparam logic [MD_OP_LEN-1:0] MD_OP_MULH  = 3'd1;
    localparam logic [MD_OP_LEN-1:0] MD_OP_MULHU = 3'd2;
    localparam logic [MD_OP_LEN-1:0] MD_OP_RSVD  = 3'd3;
    localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 3'd4;
    localparam logic [MD_OP_LEN-1:0] MD_OP_MOD   = 3'd5;
    localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 3'd6;
    localparam logic [MD_OP_LEN-1:0] MD_OP_MODU  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Divide-class opcodes; everything else (including the reserved code) multiplies.
    function automatic logic md_is_div(input logic [MD_OP_LEN-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_MOD) ||
               (op == MD_OP_DIVU) || (op == MD_OP_MODU);
    endfunction

    // The reserved code decodes as a plain low-half multiply.
    function automatic logic md_is_mul_high(input logic [MD_OP_LEN-1:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, W iterations.
module div_radix2_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    localparam int CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_dsr;

    logic [W:0]       w_shift;
    logic [W:0]       w_trial;
    logic             w_fits;

    // Partial remainder shifted left by one with the next dividend bit; a clear
    // top bit of the trial difference means the divisor fits.
    always_comb begin
        w_shift = {r_rem, r_quo[W-1]};
        w_trial = w_shift - {1'b0, r_dsr};
        w_fits  = ~w_trial[W];
    end

    // Load on start, then iterate until the counter reaches zero; the done cycle
    // is the one in which the owner collects the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(W);
            r_run <= 1'b1;
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dsr <= i_divisor;
        end else if (r_run) begin
            if (r_cnt != '0) begin
                r_rem <= w_fits ? w_trial[W-1:0] : w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], w_fits};
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_busy      = r_run;
    assign o_done      = r_run && (r_cnt == '0);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide engine: pipelined multiplier, iterative divider,
// valid/ready handshake on both sides and flush on branch mispredict.
//
// state | meaning
// IDLE  | ready for a new operation
// MUL   | product travelling through the multiplier pipeline
// DIV   | sign setup, W divider iterations, sign fixup (or divide-by-zero early out)
// DONE  | result held on the bus until MEM takes it
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int W          = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MD_OP_LEN-1:0] op,
    input  logic [W-1:0]         src_a,
    input  logic [W-1:0]         src_b,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         result,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 busy
);

    localparam int MCNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    md_state_t            r_state;
    logic [MCNT_W-1:0]    r_cnt;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [MD_OP_LEN-1:0] r_op;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_dz;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [W-1:0]         r_result;
    logic [TAG_W-1:0]     r_tag_out;

    logic [2*W-1:0]       w_a_ext;
    logic [2*W-1:0]       w_b_ext;
    logic [2*W-1:0]       w_prod;
    logic [W-1:0]         w_prod_sel;
    logic [W-1:0]         w_mul_out;

    logic                 w_div_signed;
    logic                 w_div_rem;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [W-1:0]         w_abs_a;
    logic [W-1:0]         w_abs_b;
    logic                 w_div_start;
    logic                 w_div_busy;
    logic                 w_div_done;
    logic [W-1:0]         w_div_q;
    logic [W-1:0]         w_div_r;
    logic [W-1:0]         w_q_fix;
    logic [W-1:0]         w_r_fix;

    // Full 2W-bit product; sign extension to 2W bits makes the truncated
    // product correct for MULH and the plain zero extension serves the rest.
    always_comb begin
        w_a_ext    = {{W{r_a[W-1] & (r_op == MD_OP_MULH)}}, r_a};
        w_b_ext    = {{W{r_b[W-1] & (r_op == MD_OP_MULH)}}, r_b};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_sel = md_is_mul_high(r_op) ? w_prod[2*W-1:W] : w_prod[W-1:0];
    end

    // The result register is the last multiplier stage, so only MUL_STAGES-1
    // intermediate registers are needed.
    if (MUL_STAGES == 1) begin : g_mul_direct
        assign w_mul_out = w_prod_sel;
    end else begin : g_mul_pipe
        logic [W-1:0] r_pipe [MUL_STAGES-1];

        // Product pipeline, emptied on flush.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < MUL_STAGES - 1; i++) r_pipe[i] <= '0;
            end else if (flush) begin
                for (int i = 0; i < MUL_STAGES - 1; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_prod_sel;
                for (int i = 1; i < MUL_STAGES - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_mul_out = r_pipe[MUL_STAGES-2];
    end

    // Sign handling around the unsigned divider core.
    always_comb begin
        w_div_signed = (r_op == MD_OP_DIV) || (r_op == MD_OP_MOD);
        w_div_rem    = (r_op == MD_OP_MOD) || (r_op == MD_OP_MODU);
        w_a_neg      = w_div_signed && r_a[W-1];
        w_b_neg      = w_div_signed && r_b[W-1];
        w_abs_a      = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_abs_b      = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_q_fix      = r_q_neg ? (~w_div_q + 1'b1) : w_div_q;
        w_r_fix      = r_r_neg ? (~w_div_r + 1'b1) : w_div_r;
        w_div_start  = (r_state == ST_DIV) && !r_dz && !w_div_busy && !flush;
    end

    div_radix2_core #(
        .W (W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (flush),
        .i_start     (w_div_start),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    // Main sequencer: accept, execute, present, hand off; flush beats everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_tag       <= '0;
            r_dz        <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_tag_out   <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_tag_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= src_a;
                        r_b    <= src_b;
                        r_op   <= op;
                        r_tag  <= tag_in;
                        r_busy <= 1'b1;
                        if (md_is_div(op)) begin
                            r_state <= ST_DIV;
                            r_dz    <= (src_b == '0);
                        end else begin
                            r_state <= ST_MUL;
                            r_cnt   <= MCNT_W'(MUL_STAGES - 1);
                        end
                    end
                end
                ST_MUL: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_mul_out;
                        r_tag_out   <= r_tag;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (r_dz) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_div_rem ? r_a : '1;
                        r_tag_out   <= r_tag;
                        r_out_valid <= 1'b1;
                    end else if (w_div_done) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_div_rem ? w_r_fix : w_q_fix;
                        r_tag_out   <= r_tag;
                        r_out_valid <= 1'b1;
                    end else if (!w_div_busy) begin
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_result    <= '0;
                        r_tag_out   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !flush;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.W(32), .MUL_STAGES(2), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV integer division truncates toward zero.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] ps = 64'(sa * sb);
        logic [63:0] pu = {32'b0, a} * {32'b0, b};
        logic [63:0] r;
        case (o)
            3'd1:    r = ps >> 32;
            3'd2:    r = pu >> 32;
            3'd4:    r = (b == 0) ? 64'hFFFF_FFFF : 64'(sa / sb);
            3'd5:    r = (b == 0) ? {32'b0, a}    : 64'(sa % sb);
            3'd6:    r = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
            3'd7:    r = (b == 0) ? {32'b0, a}    : 64'(ua % ub);
            default: r = ps;
        endcase
        return r[31:0];
    endfunction

    function automatic int lat_model(input logic [2:0] o, input logic [31:0] b);
        if (!o[2]) return 2;
        if (b == 0) return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                          input int hold, input string nm);
        int n;
        bit got;
        bit busy_ok;
        bit stable_ok;
        @(negedge clk);
        check({nm, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1; op = o; src_a = a; src_b = b; tag_in = tag;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom; tag_in = 5'($urandom);
        got = 0; busy_ok = busy && !in_ready; n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin got = 1; n = k; break; end
            if (!busy || in_ready || result != 0) busy_ok = 0;
        end
        check({nm, ".got_valid"}, got, 1);
        check({nm, ".busy_while_running"}, busy_ok, 1);
        if (got) begin
            check({nm, ".latency"}, n, exp_lat);
            check({nm, ".result"}, result, exp);
            check({nm, ".tag"}, tag_out, tag);
            check({nm, ".done_flags"}, {busy, in_ready}, 2'b10);
            stable_ok = 1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!out_valid || result != exp || tag_out != tag || in_ready || !busy) stable_ok = 0;
            end
            if (hold > 0) check({nm, ".held_stable"}, stable_ok, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, ".release"}, {out_valid, busy, in_ready, result}, {3'b001, 32'h0});
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; src_a = '0; src_b = '0; tag_in = '0;

        #1;
        check("reset_state", {in_ready, out_valid, busy, result, tag_out}, {3'b100, 32'h0, 5'h0});
        repeat (2) @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'd2,         5'd2,  32'hFFFF_FFFF, 2});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'd2,         5'd3,  32'h0000_0001, 2});
        vecs.push_back('{3'd3, 32'd6,          32'd7,         5'd4,  32'd42,        2});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 2});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 2});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 2});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'h7FFF_FFFC, 34});
        vecs.push_back('{3'd4, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd7, 32'd5,          32'd0,         5'd12, 32'd5,         1});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 34});
        vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 34});
        vecs.push_back('{3'd5, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'd1,         34});

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat, 0,
                   $sformatf("vec%0d", i));

        // Result held in DONE while MEM stalls.
        run_op(3'd0, 32'd1234, 32'd5678, 5'd21, 32'd7006652, 2, 10, "hold10");

        // Flush at the tenth divider iteration, with an operation offered during the flush.
        begin
            bit quiet;
            @(negedge clk);
            in_valid = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd3; tag_in = 5'd9;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            flush = 1'b1; in_valid = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9; tag_in = 5'd30;
            #1;
            check("flush.in_ready_low", in_ready, 0);
            @(posedge clk); #1;
            check("flush.idle", {busy, out_valid, result}, {2'b00, 32'h0});
            @(posedge clk); #1;
            check("flush.nothing_accepted", busy, 0);
            flush = 1'b0; in_valid = 1'b0;
            quiet = 1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (out_valid || busy) quiet = 0;
            end
            check("flush.no_late_valid", quiet, 1);
        end
        run_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 2, 0, "after_flush");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; src_a = 32'd11; src_b = 32'd13; tag_in = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mul.busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mul.async_drop", {busy, out_valid, in_ready, result}, {3'b001, 32'h0});
        @(negedge clk); rst = 1'b1;

        // Asynchronous reset while a result is presented.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; src_a = 32'd11; src_b = 32'd13; tag_in = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done.valid_before", {out_valid, result}, {1'b1, 32'd143});
        #2 rst = 1'b0;
        #1;
        check("rst_done.async_drop", {busy, out_valid, result, tag_out}, {2'b00, 32'h0, 5'h0});
        @(negedge clk); rst = 1'b1;

        run_op(3'd6, 32'd100, 32'd7, 5'd18, 32'd14, 34, 0, "post_rst_divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd19, 32'd2,  34, 0, "post_rst_modu");

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          sel;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) b = 32'($urandom_range(1, 15));
            run_op(o, a, b, 5'($urandom), model(o, a, b), lat_model(o, b), $urandom_range(0, 3),
                   $sformatf("rnd%0d_op%0d", i, o));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage. It replaces the single-cycle CAL_MUL flag path with a real execution engine that accepts one operation at a time over a valid/ready handshake. MUL* uses a MUL_STAGES-deep pipeline; DIV*/MOD* uses an iterative radix-2 divider. It drives the stall request to the hazard unit and supports flush on branch mispredict.

Parameters:
W, 32, operand/result width in bits (even, >=8)
MUL_STAGES, 2, multiply latency in cycles from accept to out_valid (>=1)
TAG_W, 5, width of the destination-register tag carried alongside the operation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk)
flush  in  1  abort the in-flight operation (branch mispredict)
in_valid  in  1  EX presents an operation
in_ready  out  1  unit can accept (IDLE and not flush)
op  in  3  MD_OP code from CPU_Parameter.vh
src_a  in  W  dividend / multiplicand (forwarded value)
src_b  in  W  divisor / multiplier (forwarded value)
tag_in  in  TAG_W  destination register
out_valid  out  1  result available
out_ready  in  1  MEM stage takes the result
result  out  W  result word
tag_out  out  TAG_W  tag of the result
busy  out  1  operation in flight or result held (stall request to hazard unit)

Behaviour:
- MD_OP: MUL=0 (low W bits), MULH=1 (signed high), MULHU=2 (unsigned high), DIV=4, MOD=5, DIVU=6, MODU=7, 3 reserved (treated as MUL).
- FSM states: IDLE, MUL, DIV, DONE. Reset -> IDLE; in_ready=1, out_valid=0, busy=0, result=0, tag_out=0, counter=0.
- Accept when in_valid && in_ready. Operands, op and tag are registered on accept. Inputs are ignored in every state other than IDLE.
- MUL: full 2W-bit product computed (signed or unsigned per op), delayed through MUL_STAGES registers. out_valid rises exactly MUL_STAGES cycles after the accept edge.
- DIV setup cycle: take absolute values for signed ops and record the quotient/remainder signs. Then W restoring iterations, one bit per cycle, counted by a clog2(W+1)-bit counter. Then one fixup cycle that applies the signs. out_valid W+2 cycles after accept.
- Divide by zero (early out, detected on accept): quotient = all ones, remainder = src_a. DONE after 1 cycle; out_valid 1 cycle after accept.
- Signed overflow (src_a = -2^(W-1), src_b = -1): quotient = -2^(W-1), remainder = 0. Takes the normal path.
- Remainder sign follows the dividend; quotient truncates toward zero.
- DONE: result/tag_out held stable while out_valid=1 && !out_ready. On out_ready -> IDLE next cycle, out_valid drops. There is no back-to-back accept in DONE (one bubble).
- busy = (state != IDLE). in_ready = (state == IDLE) && !flush.
- flush in any state: -> IDLE next edge; out_valid=0 from that edge; pipeline and counter cleared; nothing is accepted in the flush cycle. flush has priority over out_ready.
- rst asserted mid-operation: immediate return to reset values; partial results are discarded.
- result is 0 whenever out_valid=0 (no stale data on the bus).

Decomposition:
- CPU_Parameter.vh gains the MD_OP_* codes, MD_OP_LEN=3, and the state encodings.
- Sub-module div_radix2_core (restoring divider: start, W-iteration counter, done, unsigned quotient/remainder). The top module handles the sign handling, multiplier pipeline, FSM and handshake.

Test Plan:
- MUL 7 x -3 (W=32): result 0xFFFFFFEB. MULH 0x80000000 x 2 -> 0xFFFFFFFF. MULHU 0x80000000 x 2 -> 0x00000001. out_valid exactly 2 cycles after accept.
- DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. out_valid at cycle 34; busy=1 throughout.
- DIV 5/0 -> 0xFFFFFFFF and MODU 5/0 -> 5, with out_valid 1 cycle after accept. DIV 0x80000000/-1 -> 0x80000000, MOD -> 0.
- out_ready held low for 10 cycles in DONE: result/tag stable and in_ready=0 throughout. Release: IDLE next cycle, in_ready=1.
- flush at iteration 10 of a DIV: IDLE next cycle, no out_valid ever. A new MUL 3x4 issued next returns 12 with the correct tag.
- rst low mid-MUL: out_valid/busy drop asynchronously, without waiting for a clock edge. After release, DIVU 100/7 -> 14 and MODU -> 2.
